// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared RV32I pipeline constants and the IF/ID sequencer state type.
// Used by if_id_stage_ctrl, instr_field_decode and the ID stage.
package riscv_pipe_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} if_id_state_t;

endpackage

// File: rtl/if_id_stage_ctrl_if.sv
// Fetch/hazard-side bundle of the IF/ID stage; performance counter signals
// exist only when IF_ID_PERF_CNT_EN is defined.
interface if_id_stage_ctrl_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic            stall;
  logic            flush;
  logic            pc_write;
  logic            id_ex_bubble;
  logic            IF_ID_valid;
  logic [XLEN-1:0] IF_ID_pc;
  logic [31:0]     IF_ID_instr;
  logic [6:0]      IF_ID_opcode;
  logic [4:0]      IF_ID_RS1;
  logic [4:0]      IF_ID_RS2;
  logic [4:0]      IF_ID_RD;
  logic            IF_ID_branch;
  logic            stall_timeout;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_flush_cycles;
  logic [31:0]     perf_retire_slots;
`endif

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, stall, flush,
`ifdef IF_ID_PERF_CNT_EN
    input  perf_stall_cycles, perf_flush_cycles, perf_retire_slots,
`endif
    input  pc_write, id_ex_bubble, IF_ID_valid, IF_ID_pc, IF_ID_instr,
    input  IF_ID_opcode, IF_ID_RS1, IF_ID_RS2, IF_ID_RD, IF_ID_branch, stall_timeout
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, stall, flush,
`ifdef IF_ID_PERF_CNT_EN
    output perf_stall_cycles, perf_flush_cycles, perf_retire_slots,
`endif
    output pc_write, id_ex_bubble, IF_ID_valid, IF_ID_pc, IF_ID_instr,
    output IF_ID_opcode, IF_ID_RS1, IF_ID_RS2, IF_ID_RD, IF_ID_branch, stall_timeout
  );

endinterface

// File: rtl/if_id_stage_ctrl_decode.sv
// Purely combinational RV32I field extractor, shared between IF/ID and ID.
module instr_field_decode
  import riscv_pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        is_branch_o
);
  assign opcode_o    = instr_i[6:0];
  assign rs1_o       = instr_i[19:15];
  assign rs2_o       = instr_i[24:20];
  assign rd_o        = instr_i[11:7];
  assign is_branch_o = (instr_i[6:0] == OPC_BRANCH);
endmodule

// File: rtl/if_id_stage_ctrl.sv
// IF/ID pipeline register with stall/flush sequencing and a sticky stall timeout.
// Optional cycle counters are compiled in with IF_ID_PERF_CNT_EN.
module if_id_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [31:0] NOP_INSTR     = riscv_pipe_pkg::NOP_INSTR,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  if_id_stage_ctrl_if.slave bus
);
  localparam int SCW = $clog2(STALL_TIMEOUT + 1);

  if_id_state_t    state_q, state_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            to_q, to_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [6:0]      opc_q, opc_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            br_q, br_d;
  logic            pc_write_c, bubble_c, advance_c, stall_hon_c, flushing_c;

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    fcnt_d      = fcnt_q;
    to_d        = to_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_write_c  = 1'b1;
    bubble_c    = 1'b0;
    advance_c   = 1'b0;
    stall_hon_c = 1'b0;
    flushing_c  = 1'b0;
    if (bus.flush) begin
      bubble_c   = 1'b1;
      flushing_c = 1'b1;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      scnt_d     = '0;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end else if (state_q == FLUSH) begin
      // Fetch slots still in flight from the wrong path are dropped here.
      flushing_c = 1'b1;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      fcnt_d     = fcnt_q - 2'd1;
      if (fcnt_d == 2'd0) state_d = RUN;
    end else if (bus.stall) begin
      pc_write_c  = 1'b0;
      bubble_c    = 1'b1;
      stall_hon_c = 1'b1;
      state_d     = STALL;
      if (scnt_q != SCW'(STALL_TIMEOUT)) scnt_d = scnt_q + 1'b1;
      if (scnt_d == SCW'(STALL_TIMEOUT)) to_d = 1'b1;
    end else begin
      advance_c = 1'b1;
      valid_d   = bus.fetch_valid;
      pc_d      = bus.fetch_pc;
      instr_d   = bus.fetch_valid ? bus.fetch_instr : NOP_INSTR;
      scnt_d    = '0;
      state_d   = RUN;
    end
  end

  // Fields are decoded from the next word so they register alongside it.
  instr_field_decode u_decode (
    .instr_i     (instr_d),
    .opcode_o    (opc_d),
    .rs1_o       (rs1_d),
    .rs2_o       (rs2_d),
    .rd_o        (rd_d),
    .is_branch_o (br_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      scnt_q  <= '0;
      fcnt_q  <= '0;
      to_q    <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      opc_q   <= NOP_INSTR[6:0];
      rs1_q   <= NOP_INSTR[19:15];
      rs2_q   <= NOP_INSTR[24:20];
      rd_q    <= NOP_INSTR[11:7];
      br_q    <= (NOP_INSTR[6:0] == OPC_BRANCH);
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
    end
  end

  assign bus.pc_write      = pc_write_c;
  assign bus.id_ex_bubble  = bubble_c;
  assign bus.IF_ID_valid   = valid_q;
  assign bus.IF_ID_pc      = pc_q;
  assign bus.IF_ID_instr   = instr_q;
  assign bus.IF_ID_opcode  = opc_q;
  assign bus.IF_ID_RS1     = rs1_q;
  assign bus.IF_ID_RS2     = rs2_q;
  assign bus.IF_ID_RD      = rd_q;
  assign bus.IF_ID_branch  = br_q;
  assign bus.stall_timeout = to_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_retire_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_q + 32'(stall_hon_c);
      perf_flush_q  <= perf_flush_q + 32'(flushing_c);
      perf_retire_q <= perf_retire_q + 32'(advance_c & bus.fetch_valid);
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flush_cycles = perf_flush_q;
  assign bus.perf_retire_slots = perf_retire_q;
`else
  logic unused_flags;
  assign unused_flags = advance_c ^ stall_hon_c ^ flushing_c;
`endif

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Scoreboard bench for if_id_stage_ctrl built with FLUSH_CYCLES=2 and STALL_TIMEOUT=15.
module tb_if_id_stage_ctrl;
  localparam int          FC  = 2;
  localparam int          ST  = 15;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I_ADD = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_SUB = 32'h407302B3;  // sub x5,x6,x7
  localparam logic [31:0] I_OR  = 32'h00A4E433;  // or  x8,x9,x10
  localparam logic [31:0] I_BEQ = 32'h00208463;  // beq x1,x2,8

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_stage_ctrl_if #(.XLEN(32)) bus ();

  if_id_stage_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        pcw, bub, valid, to;
    logic [31:0] pc, instr;
    logic        pcw_o, bub_o, valid_o, to_o;
    logic [31:0] pc_o, instr_o;
    logic [22:0] dec_o;
  } txn_t;

  txn_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int          m_state, m_fcnt, m_scnt;
  logic        m_to, m_valid;
  logic [31:0] m_pc, m_instr;

  function automatic logic [22:0] dec(input logic [31:0] w);
    return {w[6:0], w[19:15], w[24:20], w[11:7], (w[6:0] == 7'b1100011)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_fcnt = 0; m_scnt = 0;
    m_to = 1'b0; m_valid = 1'b0; m_pc = '0; m_instr = NOP;
  endtask

  task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic st, input logic fl);
    txn_t e;
    @(negedge clk);
    bus.fetch_valid = fv; bus.fetch_pc = pc; bus.fetch_instr = instr;
    bus.stall = st; bus.flush = fl;
    #1;
    e.pcw_o = bus.pc_write;
    e.bub_o = bus.id_ex_bubble;
    if (fl) begin
      e.pcw = 1'b1; e.bub = 1'b1;
      m_valid = 1'b0; m_instr = NOP; m_scnt = 0;
      if (FC > 1) begin m_state = 2; m_fcnt = FC - 1; end else m_state = 0;
    end else if (m_state == 2) begin
      e.pcw = 1'b1; e.bub = 1'b0;
      m_valid = 1'b0; m_instr = NOP;
      m_fcnt = m_fcnt - 1;
      if (m_fcnt == 0) m_state = 0;
    end else if (st) begin
      e.pcw = 1'b0; e.bub = 1'b1;
      m_state = 1;
      if (m_scnt < ST) m_scnt = m_scnt + 1;
      if (m_scnt == ST) m_to = 1'b1;
    end else begin
      e.pcw = 1'b1; e.bub = 1'b0;
      m_valid = fv; m_pc = pc; m_instr = fv ? instr : NOP;
      m_scnt = 0; m_state = 0;
    end
    e.valid = m_valid; e.pc = m_pc; e.instr = m_instr; e.to = m_to;
    @(posedge clk); #1;
    e.valid_o = bus.IF_ID_valid; e.pc_o = bus.IF_ID_pc; e.instr_o = bus.IF_ID_instr;
    e.to_o = bus.stall_timeout;
    e.dec_o = {bus.IF_ID_opcode, bus.IF_ID_RS1, bus.IF_ID_RS2, bus.IF_ID_RD, bus.IF_ID_branch};
    $display("txn fv=%b pc=%h st=%b fl=%b -> pcw=%b bub=%b valid=%b if_pc=%h instr=%h to=%b",
             fv, pc, st, fl, e.pcw_o, e.bub_o, e.valid_o, e.pc_o, e.instr_o, e.to_o);
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0; bus.fetch_instr = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.IF_ID_valid, bus.IF_ID_instr, bus.IF_ID_pc} !== {1'b0, NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_regs: got valid=%b instr=%h pc=%h need 0/00000013/0",
               bus.IF_ID_valid, bus.IF_ID_instr, bus.IF_ID_pc);
    end
    n_checks++;
    if ({bus.IF_ID_opcode, bus.IF_ID_RS1, bus.IF_ID_RS2, bus.IF_ID_RD, bus.IF_ID_branch}
        !== {7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_fields: got opc=%b rs1=%0d rs2=%0d rd=%0d br=%b need NOP fields",
               bus.IF_ID_opcode, bus.IF_ID_RS1, bus.IF_ID_RS2, bus.IF_ID_RD, bus.IF_ID_branch);
    end
    n_checks++;
    if ({bus.pc_write, bus.id_ex_bubble, bus.stall_timeout} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got pcw/bub/to=%b%b%b need 100",
               bus.pc_write, bus.id_ex_bubble, bus.stall_timeout);
    end
  endtask

  task automatic test_stream();
    txn_t e;
    cycle(1'b1, 32'h0, I_ADD, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, I_SUB, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, I_OR,  1'b0, 1'b0);
    cycle(1'b1, 32'hC, I_BEQ, 1'b0, 1'b0);
    cycle(1'b0, 32'h10, I_OR, 1'b0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({e.pcw_o, e.bub_o} !== {e.pcw, e.bub}) begin
        n_fail++; $display("FAIL stream_ctrl: got %b%b need %b%b", e.pcw_o, e.bub_o, e.pcw, e.bub);
      end
      n_checks++;
      if ({e.valid_o, e.instr_o, e.dec_o} !== {e.valid, e.instr, dec(e.instr)}) begin
        n_fail++; $display("FAIL stream_reg: got v=%b i=%h d=%h need v=%b i=%h d=%h",
                           e.valid_o, e.instr_o, e.dec_o, e.valid, e.instr, dec(e.instr));
      end
      if (e.valid) begin
        n_checks++;
        if (e.pc_o !== e.pc) begin
          n_fail++; $display("FAIL stream_pc: got %h need %h", e.pc_o, e.pc);
        end
      end
    end
  endtask

  task automatic test_load_use();
    txn_t e;
    cycle(1'b1, 32'h10, I_ADD, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, I_SUB, 1'b1, 1'b0);
    cycle(1'b1, 32'h14, I_SUB, 1'b0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({e.pcw_o, e.bub_o} !== {e.pcw, e.bub}) begin
        n_fail++; $display("FAIL loaduse_ctrl: got %b%b need %b%b", e.pcw_o, e.bub_o, e.pcw, e.bub);
      end
      n_checks++;
      if ({e.valid_o, e.pc_o, e.instr_o, e.dec_o} !== {e.valid, e.pc, e.instr, dec(e.instr)}) begin
        n_fail++; $display("FAIL loaduse_reg: got v=%b pc=%h i=%h need v=%b pc=%h i=%h",
                           e.valid_o, e.pc_o, e.instr_o, e.valid, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_flush();
    txn_t e;
    cycle(1'b1, 32'h20, I_OR,  1'b0, 1'b0);
    cycle(1'b1, 32'h24, I_ADD, 1'b0, 1'b1);
    cycle(1'b1, 32'h28, I_SUB, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, I_BEQ, 1'b0, 1'b0);
    // stall accumulates, then stall+flush together must clear the count
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h44, I_ADD, 1'b1, 1'b0);
    cycle(1'b1, 32'h44, I_ADD, 1'b1, 1'b1);
    cycle(1'b1, 32'h48, I_ADD, 1'b1, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({e.pcw_o, e.bub_o} !== {e.pcw, e.bub}) begin
        n_fail++; $display("FAIL flush_ctrl: got %b%b need %b%b", e.pcw_o, e.bub_o, e.pcw, e.bub);
      end
      n_checks++;
      if ({e.valid_o, e.instr_o, e.dec_o, e.to_o} !== {e.valid, e.instr, dec(e.instr), e.to}) begin
        n_fail++; $display("FAIL flush_reg: got v=%b i=%h to=%b need v=%b i=%h to=%b",
                           e.valid_o, e.instr_o, e.to_o, e.valid, e.instr, e.to);
      end
    end
  endtask

  task automatic test_timeout();
    txn_t e;
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h50, I_SUB, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h50 + 32'(4 * i), I_OR, 1'b0, 1'b0);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({e.pcw_o, e.bub_o, e.to_o} !== {e.pcw, e.bub, e.to}) begin
        n_fail++; $display("FAIL timeout: got pcw/bub/to=%b%b%b need %b%b%b",
                           e.pcw_o, e.bub_o, e.to_o, e.pcw, e.bub, e.to);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    txn_t e;
    cycle(1'b1, 32'h60, I_ADD, 1'b0, 1'b1);
    void'(q.pop_front());
    do_reset();
    n_checks++;
    if ({bus.IF_ID_valid, bus.IF_ID_instr, bus.pc_write, bus.id_ex_bubble, bus.stall_timeout}
        !== {1'b0, NOP, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_flush: got v=%b i=%h pcw=%b bub=%b to=%b need 0/00000013/1/0/0",
               bus.IF_ID_valid, bus.IF_ID_instr, bus.pc_write, bus.id_ex_bubble, bus.stall_timeout);
    end
    cycle(1'b1, 32'h64, I_SUB, 1'b0, 1'b0);
    e = q.pop_front();
    n_checks++;
    if ({e.valid_o, e.pc_o, e.instr_o} !== {e.valid, e.pc, e.instr}) begin
      n_fail++; $display("FAIL rst_then_run: got v=%b pc=%h i=%h need v=%b pc=%h i=%h",
                         e.valid_o, e.pc_o, e.instr_o, e.valid, e.pc, e.instr);
    end
  endtask

  initial begin
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0; bus.fetch_instr = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_load_use();
    test_flush();
    test_timeout();
    test_reset_in_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage_ctrl.md
Name: if_id_stage_ctrl

Overview:
- IF/ID pipeline stage register plus stall/flush sequencer for the 5-stage RV32I core.
- Captures fetched PC and instruction, and pre-decodes the opcode, rs1, rs2, rd and branch fields.
- Those decoded fields feed the hazard detection unit; this block consumes that unit's stall.
- Drives PC write-enable and the ID/EX bubble, applies branch flushes, and watches for runaway stalls.

Parameters:
- XLEN, 32, PC/instruction width.
- NOP_INSTR, 32'h00000013, instruction loaded on bubble/flush (addi x0,x0,0).
- FLUSH_CYCLES, 1, number of fetch slots discarded per flush (1..3).
- STALL_TIMEOUT, 15, consecutive stall cycles before the timeout flag sets (width = clog2(STALL_TIMEOUT+1)).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- fetch_valid  in  1  fetch_pc/fetch_instr valid this cycle
- fetch_pc  in  XLEN  PC of fetched instruction
- fetch_instr  in  32  fetched instruction
- stall  in  1  load-use stall request from the hazard unit
- flush  in  1  branch/jump taken, resolved in EX
- pc_write  out  1  PC register enable
- id_ex_bubble  out  1  force ID/EX control bits to zero this cycle
- IF_ID_valid  out  1  IF/ID holds a real instruction
- IF_ID_pc  out  XLEN  registered PC
- IF_ID_instr  out  32  registered instruction
- IF_ID_opcode  out  7  instr[6:0]
- IF_ID_RS1  out  5  instr[19:15]
- IF_ID_RS2  out  5  instr[24:20]
- IF_ID_RD  out  5  instr[11:7]
- IF_ID_branch  out  1  opcode == 7'b1100011
- stall_timeout  out  1  sticky flag: stall held too long

Behaviour:
- Reset, applied at the clk edge with rst=1:
  - IF_ID_instr=NOP_INSTR, IF_ID_valid=0, IF_ID_pc=0.
  - Decoded fields are those of NOP: opcode 7'b0010011, RS1/RS2/RD=0, branch=0.
  - state=RUN, stall counter=0, flush counter=0, stall_timeout=0.
  - Combinational outputs follow from that state.
- Decoded fields are registered together with IF_ID_instr. They are never decoded combinationally from the stored word, so all fields always describe the same instruction.
- FSM states: RUN, STALL, FLUSH. Priority per cycle: flush > stall > advance.
- RUN with no stall/flush:
  - pc_write=1, id_ex_bubble=0.
  - Next edge: IF/ID loads fetch_pc/fetch_instr with IF_ID_valid=fetch_valid.
  - If fetch_valid=0, IF/ID loads NOP_INSTR with valid=0.
- stall=1 and flush=0 (RUN or STALL):
  - pc_write=0 and id_ex_bubble=1, combinationally in the same cycle.
  - IF/ID holds all fields; state goes to STALL; stall counter increments, saturating.
  - When the counter reaches STALL_TIMEOUT, stall_timeout sets and stays set until rst.
  - In STALL with stall=0: advance as in RUN, clear the counter, go to RUN.
- flush=1, in any state:
  - pc_write=1 (the PC loads the branch target externally), id_ex_bubble=1.
  - Next edge: IF/ID loads NOP_INSTR with valid=0 and the stall counter clears.
  - If FLUSH_CYCLES>1: enter FLUSH with flush counter=FLUSH_CYCLES-1; otherwise go to RUN.
- FLUSH:
  - Each cycle pc_write=1 and id_ex_bubble=0; IF/ID loads NOP (valid=0); the incoming fetch is discarded.
  - The flush counter decrements; go to RUN when it reaches 0.
  - stall is ignored in FLUSH.
  - A new flush restarts the counter at FLUSH_CYCLES-1.
- Simultaneous stall and flush: flush wins; the stall counter clears.
- rst mid-stall or mid-flush: everything returns to reset values at that edge; pc_write=1 on the following cycle.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, add three outputs, each 32-bit, counting clk edges with rst=0, wrapping at 2^32, cleared on rst:
  - perf_stall_cycles: cycles with stall honoured.
  - perf_flush_cycles: cycles in the flush or FLUSH condition.
  - perf_retire_slots: edges where IF/ID loads a valid instruction.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package riscv_pipe_pkg holds:
  - opcode constants OPC_BRANCH, OPC_OPIMM, OPC_OP, OPC_LOAD, OPC_STORE.
  - NOP_INSTR default.
  - FSM state enum if_id_state_t {RUN, STALL, FLUSH}.
- One combinational sub-module, instr_field_decode, maps a 32-bit instruction to opcode, rs1, rs2, rd and is_branch. It is reused by ID.

Test Plan:
1. Reset then stream: fetch_valid=1, pc 0x0,0x4,0x8, instructions add/sub/or → IF_ID_pc follows one cycle later; IF_ID_RS1/RS2/RD match instr bits; pc_write stays 1.
2. Load-use: stall=1 for 1 cycle while IF/ID holds add x3,x1,x2 at pc 0x10 → pc_write=0 and id_ex_bubble=1 that cycle; IF/ID still pc 0x10 next cycle; the following cycle advances to 0x14.
3. Flush with FLUSH_CYCLES=2 (pc 0x20 in IF/ID) → IF/ID becomes NOP, valid=0 for 2 consecutive edges; fetched 0x24/0x28 are dropped; state returns to RUN.
4. stall and flush asserted together → flush wins: IF/ID=NOP, pc_write=1, id_ex_bubble=1, stall counter=0.
5. stall held 15 cycles → stall_timeout rises on the edge completing the 15th cycle; stays 1 after stall drops; clears only on rst.
6. rst asserted during FLUSH → next cycle IF_ID_valid=0, IF_ID_instr=32'h00000013, pc_write=1, state RUN.
